// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared widths, FSM states and LFSR/MISR tap constants for the gate BIST controller
package gate_bist_pkg;
    localparam int IN_W  = 15;
    localparam int OUT_W = 10;
    localparam int SIG_W = 16;
    // LFSR feedback x^15 + x^14 + 1 taps bits 14 and 13
    localparam logic [IN_W-1:0]  LFSR_TAPS = 15'h6000;
    // MISR feedback taps bits 15, 13, 12 and 10
    localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;
    typedef enum logic [2:0] {IDLE, SEED, APPLY, CAPTURE, DONE} state_t;
    function automatic logic [IN_W-1:0] lfsr_next(input logic [IN_W-1:0] l);
        return {l[IN_W-2:0], ^(l & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/gate_bist_misr.sv
// gate_bist_misr: 16-bit multiple-input signature register compacting the gate-model response
module gate_bist_misr
    import gate_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [OUT_W-1:0] i_data,
    output logic [SIG_W-1:0] o_sig,
    output logic [SIG_W-1:0] o_next
);
    logic [SIG_W-1:0] r_sig;
    // shift with tap feedback, then fold in the response word
    always_comb o_next = {r_sig[SIG_W-2:0], ^(r_sig & MISR_TAPS)} ^ {{(SIG_W-OUT_W){1'b0}}, i_data};
    // clear at run seed, compact only on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sig <= '0;
        else if (i_clr) r_sig <= '0;
        else if (i_en) r_sig <= o_next;
    end
    assign o_sig = r_sig;
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR pattern BIST controller for a 15-in/10-out gate model; optional abort input under GATE_BIST_ABORT_EN
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int              NUM_PATTERNS  = 1000,
    parameter logic [IN_W-1:0] LFSR_SEED     = 15'h0001,
    parameter int              SETTLE_CYCLES = 1,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef GATE_BIST_ABORT_EN
    input  logic             abort,
`endif
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);
    // an all-zero seed would lock the LFSR, so it falls back to 1
    localparam logic [IN_W-1:0] SEED_VAL    = (LFSR_SEED == '0) ? 15'h0001 : LFSR_SEED;
    localparam logic [15:0]     LAST_PAT    = 16'(NUM_PATTERNS - 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [IN_W-1:0]  r_lfsr;
    logic [15:0]      r_cnt;
    logic [7:0]       r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             w_abort;
    logic [SIG_W-1:0] w_misr_next;

`ifdef GATE_BIST_ABORT_EN
    assign w_abort = abort && (r_state == APPLY || r_state == CAPTURE);
`else
    assign w_abort = 1'b0;
`endif

    gate_bist_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state == SEED),
        .i_en   (r_state == CAPTURE && !w_abort),
        .i_data (dut_out),
        .o_sig  (signature),
        .o_next (w_misr_next)
    );

    // run sequencing, pattern generation and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lfsr   <= SEED_VAL;
            r_cnt    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else if (w_abort) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SEED;
                        r_busy  <= 1'b1;
                    end
                end
                SEED: begin
                    r_lfsr   <= SEED_VAL;
                    r_cnt    <= '0;
                    r_settle <= '0;
                    r_pass   <= 1'b0;
                    r_state  <= APPLY;
                end
                APPLY: begin
                    r_settle <= (r_settle == SETTLE_LAST) ? '0 : r_settle + 8'd1;
                    if (r_settle == SETTLE_LAST) r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_lfsr <= lfsr_next(r_lfsr);
                    r_cnt  <= r_cnt + 16'd1;
                    if (r_cnt == LAST_PAT) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        // judged on the final signature so pass is valid alongside done
                        r_pass  <= (w_misr_next == GOLDEN_SIG);
                    end else begin
                        r_state <= APPLY;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dut_in = r_lfsr;
    assign busy   = r_busy;
    assign done   = r_done;
    assign pass   = r_pass;
endmodule
